rpc_dram_responder: RTL and testbench
=====================================

# rpc_dram_responder

Synthesizable device-side responder for the RPC DRAM link: it sits on the DRAM end of the controller's pad interface (CSN/STB/DB/DQS) and serves read and write bursts from an internal beat-addressed memory. It decodes two-beat command packets, absorbs masked write bursts and returns read bursts with a source-driven DQS strobe. It is used as the FPGA-emulation DRAM stand-in and as the closed-loop bench target for the controller PHY. The link is single-data-rate on the `clk_i` domain: one 16-bit beat per cycle.

## Interface
- `MemAddrWidth`, 12: log2 of memory depth in 16-bit beats.
- `ReadLatency`, 4: cycles from the command high-half edge to the first read beat; legal range ≥2.
- `WriteLatency`, 2: cycles from the command high-half edge to the first write-beat sample; legal range ≥1.
- `clk_i`  in  1  link clock; all sampling on the rising edge.
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low.
- `csn_i`  in  1  chip select, active-low; high aborts any transaction.
- `stb_i`  in  1  strobe; low frames command beats; low during a write beat masks that beat.
- `db_i`  in  16  data/command bus from controller.
- `db_o`  out  16  read data, registered.
- `db_oe_o`  out  1  DB output enable.
- `dqs_o`  out  1  read strobe, registered.
- `dqs_oe_o`  out  1  DQS output enable.
- `busy_o`  out  1  high whenever the FSM is not IDLE.
- `err_o`  out  1  one-cycle pulse on a malformed or reserved command.

## Operation
- Command packet: 32 bits, low half first. `[31:30]` opcode (00 NOP, 01 WR, 10 RD, 11 reserved). `[29:24]` len = words−1. `[23:20]` ignored. `[19:0]` word address.
- One word is 16 beats. Beat pointer start = `{word_addr, 4'b0}`, truncated to `MemAddrWidth`.
- The pointer increments by 1 per beat, modulo 2^`MemAddrWidth`; wrap is silent.
- Burst length = 16·(len+1) beats, from 16 to 1024.
- FSM states: IDLE, CMD_HI, WR_LAT, WR_DATA, RD_LAT, RD_DATA.
- IDLE → CMD_HI: `csn_i`=0 and `stb_i`=0 sampled; `db_i` is captured as cmd[15:0].
- CMD_HI, `stb_i`=0: `db_i` is captured as cmd[31:16], then decoded:
  - WR → WR_LAT.
  - RD → RD_LAT.
  - NOP → IDLE.
  - 11 → IDLE and pulse `err_o`.
- CMD_HI, `stb_i`=1: → IDLE and pulse `err_o`.
- WR_DATA: every cycle writes `db_i` to mem[ptr] unless `stb_i`=0 (masked beat); the pointer advances either way. After the last beat → IDLE.
- RD_DATA: `db_o` ← mem[ptr] each cycle, `db_oe_o`=1. For beat k, `dqs_o` = ~k[0] (pattern 1,0,1,0…). After the last beat → IDLE.
- `csn_i`=1 sampled in any non-IDLE state forces IDLE at that edge:
  - that cycle's write is suppressed;
  - `db_oe_o` and `dqs_oe_o` drop at that edge;
  - `err_o` is not pulsed.
- Memory contents are not reset.
- A new command is accepted in the cycle immediately after a burst's last beat; there is no turnaround gap.

## Timing
- Reset values: `db_o`=0, `db_oe_o`=0, `dqs_o`=0, `dqs_oe_o`=0, `busy_o`=0, `err_o`=0, state IDLE. Reset asserted mid-burst returns everything to these values immediately (asynchronous).
- Let edge E1 be the edge that samples the command high half.
- Write: first data beat sampled at E1+`WriteLatency`; the last beat at E1+`WriteLatency`+16(len+1)−1.
- Read:
  - Preamble: at edge E1+`ReadLatency`−1, `dqs_oe_o`=1 and `dqs_o`=0; `db_oe_o` stays 0.
  - Beat k is valid on `db_o` after edge E1+`ReadLatency`+k and holds for one cycle.
  - At the edge after the last beat, both OEs return to 0, `dqs_o` returns to 0 and the FSM returns to IDLE.
- `busy_o` rises at the edge that samples the command low half and falls at the edge the FSM enters IDLE.
- `err_o` is high for exactly the cycle following the offending edge.
- Read-after-write to the same beat returns the new data as soon as the write burst has completed.

## Test plan
- Write-then-read: WR, addr 0x00010, len 0, beats 0x1000+k; then RD of the same address. Required: read beats 0x1000..0x100F, first beat at E1+4, DQS 1,0,1,0…, preamble observed at E1+3.
- Masked write: mem preloaded with 0xFFFF; WR len 0 with `stb_i`=0 on beats 3 and 7. Required: RD returns 0xFFFF at beats 3 and 7 and the written data elsewhere.
- Wrap: `MemAddrWidth`=12, WR addr 0x000FF, len 1 (32 beats). Required: beats 16..31 land at beat addresses 0x000..0x00F; a read of addr 0 returns them.
- Abort: RD len 3; `csn_i` goes high after beat 5. Required: OEs drop at that edge, `busy_o`=0 next cycle, `err_o` stays 0; the next command is accepted normally.
- Errors: command with opcode 11, and a command with `stb_i`=1 in the high-half cycle. Required: one `err_o` pulse each, FSM in IDLE, memory unchanged.
- Back-to-back: WR len 0 followed immediately by RD len 0 starting the cycle after the last write beat. Required: the RD is accepted and returns the just-written data.

Source files
------------

// File: rtl/rpc_dram_responder.sv
// rtl/rpc_dram_responder.sv - device-side RPC DRAM burst responder
//
// Purpose: sits on the DRAM end of the RPC pad interface and serves masked
// write bursts and read bursts out of an internal beat-addressed memory.
// Commands are two 16-bit beats framed by stb_i low; one beat per clock.
//
// Ports:
//   clk_i, rst_ni        link clock, asynchronous active-low reset
//   csn_i                chip select (active-low); high aborts any transaction
//   stb_i                command framing; low during a write beat masks it
//   db_i[15:0]           command / write data from the controller
//   db_o[15:0], db_oe_o  registered read data and its output enable
//   dqs_o, dqs_oe_o      registered read strobe and its output enable
//   busy_o               FSM not idle
//   err_o                one-cycle pulse on a malformed or reserved command

module rpc_dram_responder #(
  parameter int MemAddrWidth = 12,
  parameter int ReadLatency  = 4,
  parameter int WriteLatency = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        csn_i,
  input  logic        stb_i,
  input  logic [15:0] db_i,
  output logic [15:0] db_o,
  output logic        db_oe_o,
  output logic        dqs_o,
  output logic        dqs_oe_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int Depth  = 1 << MemAddrWidth;
  localparam int LatMax = (ReadLatency > WriteLatency) ? ReadLatency : WriteLatency;
  localparam int LatW   = (LatMax < 2) ? 1 : $clog2(LatMax);
  localparam logic [LatW-1:0] RdLatLoad = LatW'(ReadLatency - 2);
  localparam logic [LatW-1:0] WrLatLoad = (WriteLatency >= 2) ? LatW'(WriteLatency - 2) : '0;

  localparam logic [1:0] OpNop = 2'b00;
  localparam logic [1:0] OpWr  = 2'b01;
  localparam logic [1:0] OpRd  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_HI, S_WR_LAT, S_WR_DATA, S_RD_LAT, S_RD_DATA
  } state_e;

  state_e                   state_q, state_d;
  logic [15:0]              cmd_lo_q, cmd_lo_d;
  logic [5:0]               len_q, len_d;
  logic [MemAddrWidth-1:0]  ptr_q, ptr_d;
  logic [10:0]              cnt_q, cnt_d;
  logic [LatW-1:0]          lat_q, lat_d;
  logic [15:0]              db_q, db_d;
  logic                     db_oe_q, db_oe_d;
  logic                     dqs_q, dqs_d;
  logic                     dqs_oe_q, dqs_oe_d;
  logic                     err_q, err_d;
  logic                     mem_we;

  logic [15:0] mem [Depth];

  logic [1:0]  op;
  logic [10:0] last_idx;
  logic        abort;
  logic        rd_end;

  assign op       = db_i[15:14];
  assign last_idx = {1'b0, len_q, 4'hF};
  assign abort    = (state_q != S_IDLE) && csn_i;
  // Read data stays in RD_DATA one cycle past the last beat so the final
  // beat holds for a full cycle before the enables drop.
  assign rd_end   = (cnt_q == last_idx + 11'd1);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cmd_lo_q <= '0;
      len_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      lat_q    <= '0;
      db_q     <= '0;
      db_oe_q  <= 1'b0;
      dqs_q    <= 1'b0;
      dqs_oe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_lo_q <= cmd_lo_d;
      len_q    <= len_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      db_q     <= db_d;
      db_oe_q  <= db_oe_d;
      dqs_q    <= dqs_d;
      dqs_oe_q <= dqs_oe_d;
      err_q    <= err_d;
    end
  end

  // Memory array: contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[ptr_q] <= db_i;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (!csn_i && !stb_i) state_d = S_CMD_HI;
        S_CMD_HI: begin
          if (stb_i)            state_d = S_IDLE;
          else if (op == OpWr)  state_d = (WriteLatency == 1) ? S_WR_DATA : S_WR_LAT;
          else if (op == OpRd)  state_d = S_RD_LAT;
          else                  state_d = S_IDLE;
        end
        S_WR_LAT:  if (lat_q == '0) state_d = S_WR_DATA;
        S_WR_DATA: if (cnt_q == last_idx) state_d = S_IDLE;
        S_RD_LAT:  if (lat_q == '0) state_d = S_RD_DATA;
        S_RD_DATA: if (rd_end) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    cmd_lo_d = cmd_lo_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    db_d     = '0;
    db_oe_d  = 1'b0;
    dqs_d    = 1'b0;
    dqs_oe_d = 1'b0;
    err_d    = 1'b0;
    mem_we   = 1'b0;
    if (!abort) begin
      case (state_q)
        S_IDLE: if (!csn_i && !stb_i) cmd_lo_d = db_i;
        S_CMD_HI: begin
          if (stb_i) begin
            err_d = 1'b1;
          end else begin
            len_d = db_i[13:8];
            // Word address scaled to beats; upper bits fall off the memory.
            ptr_d = MemAddrWidth'({db_i[3:0], cmd_lo_q, 4'b0000});
            cnt_d = '0;
            lat_d = (op == OpRd) ? RdLatLoad : WrLatLoad;
            if (op != OpNop && op != OpWr && op != OpRd) err_d = 1'b1;
          end
        end
        S_WR_LAT: lat_d = lat_q - LatW'(1);
        S_WR_DATA: begin
          mem_we = stb_i;
          ptr_d  = ptr_q + MemAddrWidth'(1);
          cnt_d  = cnt_q + 11'd1;
        end
        S_RD_LAT: begin
          lat_d = lat_q - LatW'(1);
          // Preamble: strobe driven low one cycle ahead of the first beat.
          if (lat_q == '0) dqs_oe_d = 1'b1;
        end
        S_RD_DATA: begin
          if (!rd_end) begin
            db_d     = mem[ptr_q];
            db_oe_d  = 1'b1;
            dqs_oe_d = 1'b1;
            dqs_d    = ~cnt_q[0];
            ptr_d    = ptr_q + MemAddrWidth'(1);
            cnt_d    = cnt_q + 11'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign db_o     = db_q;
  assign db_oe_o  = db_oe_q;
  assign dqs_o    = dqs_q;
  assign dqs_oe_o = dqs_oe_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_rpc_dram_responder.sv
// tb/tb_rpc_dram_responder.sv - self-checking bench for rpc_dram_responder

module tb_rpc_dram_responder;

  localparam int AW    = 12;
  localparam int RL    = 4;
  localparam int WL    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MAXC  = 20000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        csn_i, stb_i;
  logic [15:0] db_i;
  logic [15:0] db_o;
  logic        db_oe_o, dqs_o, dqs_oe_o, busy_o, err_o;

  rpc_dram_responder #(.MemAddrWidth(AW), .ReadLatency(RL), .WriteLatency(WL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .csn_i(csn_i), .stb_i(stb_i), .db_i(db_i),
    .db_o(db_o), .db_oe_o(db_oe_o), .dqs_o(dqs_o), .dqs_oe_o(dqs_oe_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int shown = 0;
  bit chk_en = 1'b0;

  // Model memory and per-edge expected outputs (index = edge number).
  bit [15:0] m_mem [DEPTH];
  bit [15:0] e_db [MAXC];
  bit        e_dboe [MAXC], e_dqsoe [MAXC], e_dqs [MAXC], e_busy [MAXC], e_err [MAXC];
  bit [15:0] h_db [MAXC];
  bit        h_dboe [MAXC], h_dqsoe [MAXC], h_dqs [MAXC], h_busy [MAXC], h_err [MAXC];
  bit [15:0] wdata [1024];
  bit        wmask [1024];

  always @(negedge clk) begin : compare
    bit ok;
    if (cyc < MAXC) begin
      h_db[cyc] = db_o; h_dboe[cyc] = db_oe_o; h_dqsoe[cyc] = dqs_oe_o;
      h_dqs[cyc] = dqs_o; h_busy[cyc] = busy_o; h_err[cyc] = err_o;
      if (chk_en) begin
        tests++;
        ok = (db_oe_o === e_dboe[cyc]) && (dqs_oe_o === e_dqsoe[cyc]) &&
             (busy_o === e_busy[cyc]) && (err_o === e_err[cyc]) &&
             (!e_dboe[cyc] || db_o === e_db[cyc]) &&
             (!e_dqsoe[cyc] || dqs_o === e_dqs[cyc]);
        if (!ok) begin
          fails++;
          if (shown < 40) begin
            shown++;
            $display("FAIL cycle_outputs @edge %0d: got db=%h oe=%b dqs=%b dqsoe=%b busy=%b err=%b, want db=%h oe=%b dqs=%b dqsoe=%b busy=%b err=%b",
                     cyc, db_o, db_oe_o, dqs_o, dqs_oe_o, busy_o, err_o,
                     e_db[cyc], e_dboe[cyc], e_dqs[cyc], e_dqsoe[cyc], e_busy[cyc], e_err[cyc]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkcmd(input logic [1:0] op, input int len, input logic [19:0] addr);
    return {op, 6'(len), 4'b0000, addr};
  endfunction

  // Write burst rules: beat k sampled at E1+WL+k, idle after the last beat,
  // abort edge E1+ab suppresses that beat and everything after it.
  function automatic void sched_wr(input int l, input logic [19:0] addr, input int len, input int ab);
    int e1 = l + 1;
    int n = 16 * (len + 1);
    int start = (int'(addr) * 16) % DEPTH;
    int a = (ab >= 0) ? e1 + ab : 32'h3fff_ffff;
    int iend = e1 + WL + n - 1;
    if (a < iend) iend = a;
    for (int i = l; i < iend; i++) e_busy[i] = 1'b1;
    for (int k = 0; k < n; k++)
      if (e1 + WL + k < a && !wmask[k]) m_mem[(start + k) % DEPTH] = wdata[k];
  endfunction

  // Read burst rules: preamble at E1+RL-1, beat k at E1+RL+k, idle at E1+RL+n.
  function automatic void sched_rd(input int l, input logic [19:0] addr, input int len, input int ab);
    int e1 = l + 1;
    int n = 16 * (len + 1);
    int start = (int'(addr) * 16) % DEPTH;
    int a = (ab >= 0) ? e1 + ab : 32'h3fff_ffff;
    int iend = e1 + RL + n;
    if (a < iend) iend = a;
    for (int i = l; i < iend; i++) e_busy[i] = 1'b1;
    if (e1 + RL - 1 < iend) begin e_dqsoe[e1 + RL - 1] = 1'b1; e_dqs[e1 + RL - 1] = 1'b0; end
    for (int k = 0; k < n; k++) begin
      if (e1 + RL + k < iend) begin
        e_db[e1 + RL + k]    = m_mem[(start + k) % DEPTH];
        e_dboe[e1 + RL + k]  = 1'b1;
        e_dqsoe[e1 + RL + k] = 1'b1;
        e_dqs[e1 + RL + k]   = (k % 2 == 0);
      end
    end
  endfunction

  task automatic step(input bit c, input bit s, input logic [15:0] d);
    csn_i = c; stb_i = s; db_i = d;
    @(posedge clk); #1;
    if (cyc > MAXC - 200) begin
      fails++;
      $display("FAIL cycle_budget: edge %0d beyond limit %0d", cyc, MAXC - 200);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
    end
  endtask

  task automatic fill(input int n, input int base, input bit rnd, input bit rmask);
    for (int k = 0; k < 1024; k++) begin
      wdata[k] = rnd ? 16'($urandom) : 16'(base + k);
      wmask[k] = rmask ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
  endtask

  task automatic do_wr(input logic [19:0] addr, input int len, input int ab, output int e1);
    int l = cyc + 1;
    int n = 16 * (len + 1);
    logic [31:0] c = mkcmd(2'b01, len, addr);
    bit stop = 1'b0;
    sched_wr(l, addr, len, ab);
    step(1'b0, 1'b0, c[15:0]);
    step(1'b0, 1'b0, c[31:16]);
    e1 = cyc;
    for (int i = 1; i < WL; i++) step(1'b0, 1'b1, 16'($urandom));
    for (int k = 0; k < n; k++) begin
      if (!stop) begin
        if (ab >= 0 && WL + k == ab) begin step(1'b1, 1'b1, 16'($urandom)); stop = 1'b1; end
        else step(1'b0, !wmask[k], wdata[k]);
      end
    end
  endtask

  task automatic do_rd(input logic [19:0] addr, input int len, input int ab, output int e1);
    int l = cyc + 1;
    int n = 16 * (len + 1);
    logic [31:0] c = mkcmd(2'b10, len, addr);
    bit stop = 1'b0;
    sched_rd(l, addr, len, ab);
    step(1'b0, 1'b0, c[15:0]);
    step(1'b0, 1'b0, c[31:16]);
    e1 = cyc;
    for (int i = 1; i <= RL + n; i++) begin
      if (!stop) begin
        if (ab >= 0 && i == ab) begin step(1'b1, 1'b1, 16'($urandom)); stop = 1'b1; end
        else step(1'b0, 1'b1, 16'($urandom));
      end
    end
  endtask

  // kind 0: reserved opcode; kind 1: stb high during the high-half beat.
  task automatic do_err(input bit kind, output int e1);
    int l = cyc + 1;
    logic [31:0] c = mkcmd(kind ? 2'b01 : 2'b11, 0, 20'h00001);
    e_busy[l] = 1'b1;
    e_err[l + 1] = 1'b1;
    step(1'b0, 1'b0, c[15:0]);
    step(1'b0, kind, c[31:16]);
    e1 = cyc;
  endtask

  task automatic do_nop();
    int l = cyc + 1;
    logic [31:0] c = mkcmd(2'b00, 5, 20'h00003);
    e_busy[l] = 1'b1;
    step(1'b0, 1'b0, c[15:0]);
    step(1'b0, 1'b0, c[31:16]);
  endtask

  initial begin
    int e1, cnt, len, kind, ab;
    logic [19:0] addr;
    rst_ni = 1'b0; csn_i = 1'b1; stb_i = 1'b1; db_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_db_o", db_o, 0);
    chk("reset_db_oe", db_oe_o, 0);
    chk("reset_dqs_o", dqs_o, 0);
    chk("reset_dqs_oe", dqs_oe_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_err", err_o, 0);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // Fill all 4096 beats so every later read has a defined model value.
    for (int w = 0; w < 4; w++) begin
      fill(1024, 0, 1'b1, 1'b0);
      do_wr(20'(w * 64), 63, -1, e1);
    end

    // Write-then-read at word 0x10.
    fill(16, 16'h1000, 1'b0, 1'b0);
    do_wr(20'h00010, 0, -1, e1);
    step(1'b1, 1'b1, 16'h0);
    do_rd(20'h00010, 0, -1, e1);
    step(1'b1, 1'b1, 16'h0);
    chk("wr_rd_preamble_dqsoe", h_dqsoe[e1 + 3], 1);
    chk("wr_rd_preamble_dboe", h_dboe[e1 + 3], 0);
    chk("wr_rd_preamble_dqs", h_dqs[e1 + 3], 0);
    chk("wr_rd_first_beat_oe", h_dboe[e1 + 4], 1);
    chk("wr_rd_beat0", h_db[e1 + 4], 16'h1000);
    chk("wr_rd_beat15", h_db[e1 + 19], 16'h100F);
    chk("wr_rd_dqs_beat0", h_dqs[e1 + 4], 1);
    chk("wr_rd_dqs_beat1", h_dqs[e1 + 5], 0);
    chk("wr_rd_oe_after_last", h_dboe[e1 + 20], 0);
    chk("wr_rd_busy_after_last", h_busy[e1 + 20], 0);

    // Masked write over a 0xFFFF preload.
    fill(16, 16'hFFFF, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) wdata[k] = 16'hFFFF;
    do_wr(20'h00010, 0, -1, e1);
    fill(16, 16'h3000, 1'b0, 1'b0);
    wmask[3] = 1'b1; wmask[7] = 1'b1;
    do_wr(20'h00010, 0, -1, e1);
    fill(16, 0, 1'b0, 1'b0);
    do_rd(20'h00010, 0, -1, e1);
    step(1'b1, 1'b1, 16'h0);
    chk("mask_beat3", h_db[e1 + 7], 16'hFFFF);
    chk("mask_beat7", h_db[e1 + 11], 16'hFFFF);
    chk("mask_beat4", h_db[e1 + 8], 16'h3004);

    // Wrap: word 0xFF, 32 beats; second half lands at beat 0.
    fill(32, 16'h2000, 1'b0, 1'b0);
    do_wr(20'h000FF, 1, -1, e1);
    do_rd(20'h00000, 0, -1, e1);
    step(1'b1, 1'b1, 16'h0);
    chk("wrap_beat0", h_db[e1 + 4], 16'h2010);
    chk("wrap_beat15", h_db[e1 + 19], 16'h201F);

    // Abort a 64-beat read right after beat 5.
    do_rd(20'h00040, 3, RL + 6, e1);
    step(1'b1, 1'b1, 16'h0);
    cnt = 0;
    for (int i = e1; i < e1 + RL + 70; i++) cnt += h_dboe[i] + h_err[i];
    chk("abort_beats_seen", cnt, 6);
    chk("abort_dqsoe_drop", h_dqsoe[e1 + RL + 6], 0);
    chk("abort_busy_drop", h_busy[e1 + RL + 6], 0);
    do_rd(20'h00010, 0, -1, e1);

    // Error commands; the following read confirms memory was not touched.
    do_err(1'b0, e1);
    step(1'b1, 1'b1, 16'h0);
    chk("err_op11_pulse", h_err[e1], 1);
    chk("err_op11_width", h_err[e1 + 1], 0);
    chk("err_op11_idle", h_busy[e1], 0);
    do_err(1'b1, e1);
    step(1'b1, 1'b1, 16'h0);
    chk("err_stb_pulse", h_err[e1], 1);
    chk("err_stb_idle", h_busy[e1], 0);
    do_rd(20'h00001, 0, -1, e1);
    do_nop();

    // Back-to-back write then read with no gap.
    fill(16, 16'h4000, 1'b0, 1'b0);
    do_wr(20'h00020, 0, -1, e1);
    do_rd(20'h00020, 0, -1, e1);
    step(1'b1, 1'b1, 16'h0);
    chk("b2b_beat0", h_db[e1 + 4], 16'h4000);
    chk("b2b_beat15", h_db[e1 + 19], 16'h400F);

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      addr = 20'($urandom);
      len  = $urandom_range(0, 3);
      ab   = -1;
      if (kind <= 3) begin
        fill(16 * (len + 1), 0, 1'b1, 1'b1);
        if ($urandom_range(0, 5) == 0) ab = $urandom_range(WL, WL + 16 * (len + 1) - 1);
        do_wr(addr, len, ab, e1);
      end else if (kind <= 7) begin
        if ($urandom_range(0, 5) == 0) ab = $urandom_range(1, RL + 16 * (len + 1) - 1);
        do_rd(addr, len, ab, e1);
      end else if (kind == 8) begin
        do_nop();
      end else begin
        do_err(1'($urandom_range(0, 1)), e1);
      end
      repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b1, 16'($urandom));
    end

    // Asynchronous reset in the middle of a read burst.
    begin
      int l;
      logic [31:0] c;
      l = cyc + 1;
      c = mkcmd(2'b10, 0, 20'h00020);
      sched_rd(l, 20'h00020, 0, -1);
      step(1'b0, 1'b0, c[15:0]);
      step(1'b0, 1'b0, c[31:16]);
      repeat (RL + 2) step(1'b0, 1'b1, 16'($urandom));
      for (int i = cyc; i < MAXC; i++) begin
        e_dboe[i] = 1'b0; e_dqsoe[i] = 1'b0; e_busy[i] = 1'b0; e_err[i] = 1'b0;
      end
      #2 rst_ni = 1'b0;
      #1;
      chk("async_rst_db_oe", db_oe_o, 0);
      chk("async_rst_dqs_oe", dqs_oe_o, 0);
      chk("async_rst_busy", busy_o, 0);
      chk("async_rst_db_o", db_o, 0);
      step(1'b1, 1'b1, 16'h0);
      step(1'b1, 1'b1, 16'h0);
      rst_ni = 1'b1;
    end
    do_rd(20'h00020, 0, -1, e1);
    step(1'b1, 1'b1, 16'h0);
    chk("post_rst_beat0", h_db[e1 + 4], 16'h4000);

    repeat (3) step(1'b1, 1'b1, 16'h0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
